seg7_scan_ctrl: RTL and testbench

- Parametrised multiplexed 7-segment scan driver; successor to the fixed 8-digit display path of the digital clock top.
- Adds the following over the fixed path: configurable digit count, anti-ghost blanking interval, per-slot PWM brightness, leading-zero suppression, per-digit blanking and decimal points, and output polarity options.
- Double-buffered input; new values take effect only at frame boundaries, so no torn frames.
- Sits between the timekeeping core and the board 7-segment pins.

---
 rtl/seg7_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan driver: double-buffered frame data, anti-ghost blanking,
// PWM brightness, leading-zero suppression and selectable output polarities.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int DIGIT_TICKS    = 3125,
  parameter int BLANK_TICKS    = 16,
  parameter int BRIGHT_W       = 4,
  parameter bit EN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [NUM_DIGITS-1:0]   seg_en,
  output logic [7:0]              seg_data,
  output logic [3:0]              cur_digit,
  output logic                    frame_done
);

  localparam int T_W     = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int TE_W    = T_W + 1;
  localparam int K_IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int A_TICKS = DIGIT_TICKS - BLANK_TICKS;
  localparam int P_W     = TE_W + BRIGHT_W;

  localparam logic [T_W-1:0]  T_LAST = T_W'(DIGIT_TICKS - 1);
  localparam logic [K_IW-1:0] K_LAST = K_IW'(NUM_DIGITS - 1);

  if (BLANK_TICKS >= DIGIT_TICKS) begin : g_bad_blank
    $error("seg7_scan_ctrl: BLANK_TICKS must be less than DIGIT_TICKS");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("seg7_scan_ctrl: NUM_DIGITS must be in 1..16");
  end

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lz;
    logic [BRIGHT_W-1:0]     bright;
  } frame_cfg_t;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h77;
      4'hB:    glyph = 7'h7C;
      4'hC:    glyph = 7'h39;
      4'hD:    glyph = 7'h5E;
      4'hE:    glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  logic [T_W-1:0]  t;
  logic [K_IW-1:0] k;
  logic            wrap;
  logic            wrap_q;
  frame_cfg_t      load_cfg;
  frame_cfg_t      pend;
  frame_cfg_t      act;

  assign wrap     = (k == K_LAST) && (t == T_LAST);
  assign load_cfg = '{digits: digits_bcd, dp: dp_mask, blank: blank_mask,
                      lz: lz_suppress, bright: bright};

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      t <= '0;
      k <= '0;
    end else if (t == T_LAST) begin
      t <= '0;
      k <= (k == K_LAST) ? '0 : k + 1'b1;
    end else begin
      t <= t + 1'b1;
    end
  end

  // Pending captures every load; active only changes on the frame wrap, so a frame is never torn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend <= '0;
      act  <= '0;
    end else begin
      if (load) pend <= load_cfg;
      if (wrap) act  <= pend;
    end
  end

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;

  always_comb begin
    // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
    lz_mask  = '0;
    zero_run = act.lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (act.digits[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_run;
    end
  end

  logic [P_W-1:0]        on_prod;
  logic [TE_W-1:0]       on_end;
  logic [3:0]            nibble;
  logic                  sup;
  logic                  en_now;
  logic [NUM_DIGITS-1:0] en_vec;
  logic [7:0]            data_vec;

  assign on_prod  = P_W'(A_TICKS) * (P_W'(act.bright) + P_W'(1));
  assign on_end   = TE_W'(BLANK_TICKS) + TE_W'(on_prod >> BRIGHT_W);
  assign nibble   = act.digits[{k, 2'b00} +: 4];
  assign sup      = lz_mask[k];
  // A suppressed digit stays lit only to show its decimal point.
  assign en_now   = ({1'b0, t} >= TE_W'(BLANK_TICKS)) && ({1'b0, t} < on_end) &&
                    !act.blank[k] && (!sup || act.dp[k]);
  assign en_vec   = en_now ? (NUM_DIGITS'(1) << k) : '0;
  assign data_vec = {act.dp[k], sup ? 7'h00 : glyph(nibble)};

  // frame_done is delayed one extra cycle so it lines up with digit 0's first output cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg_en     <= {NUM_DIGITS{EN_ACTIVE_LOW}};
      seg_data   <= {8{SEG_ACTIVE_LOW}};
      cur_digit  <= '0;
      wrap_q     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      seg_en     <= en_vec ^ {NUM_DIGITS{EN_ACTIVE_LOW}};
      seg_data   <= data_vec ^ {8{SEG_ACTIVE_LOW}};
      cur_digit  <= 4'(k);
      wrap_q     <= wrap;
      frame_done <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboarded bench for seg7_scan_ctrl: a driver predicts every output cycle from a
// frame-level model of the display rules; a monitor compares each registered output.
module tb_seg7_scan_ctrl;

  localparam int N   = 4;
  localparam int DT  = 20;
  localparam int BT  = 4;
  localparam int BW  = 2;
  localparam int NDT = N * DT;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load;
  logic [15:0] digits_bcd;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic        lz_suppress;
  logic [1:0]  bright;
  logic [3:0]  seg_en;
  logic [7:0]  seg_data;
  logic [3:0]  cur_digit;
  logic        frame_done;

  seg7_scan_ctrl #(
    .NUM_DIGITS(N), .DIGIT_TICKS(DT), .BLANK_TICKS(BT), .BRIGHT_W(BW),
    .EN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .resetn(resetn), .load(load), .digits_bcd(digits_bcd),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .lz_suppress(lz_suppress),
    .bright(bright), .seg_en(seg_en), .seg_data(seg_data),
    .cur_digit(cur_digit), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] en;
    logic [7:0] data;
    logic [3:0] cur;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: what has been loaded (pending) and what the current frame shows (active).
  logic [15:0] p_digits, a_digits;
  logic [3:0]  p_dp, a_dp, p_blank, a_blank;
  logic        p_lz, a_lz;
  logic [1:0]  p_bright, a_bright;

  task automatic clear_model();
    p_digits = '0; p_dp = '0; p_blank = '0; p_lz = 1'b0; p_bright = '0;
    a_digits = '0; a_dp = '0; a_blank = '0; a_lz = 1'b0; a_bright = '0;
  endtask

  // Expected output for the cycle at position c since reset release, from the display rules.
  function automatic exp_t expect_cycle(int c);
    exp_t e;
    int   kk, tt, on_ticks;
    bit   sup, show;
    kk       = (c / DT) % N;
    tt       = c % DT;
    on_ticks = ((DT - BT) * (int'(a_bright) + 1)) / (1 << BW);
    sup      = a_lz && (kk != 0);
    for (int j = kk; j < N; j++)
      if (a_digits[4*j +: 4] != 4'd0) sup = 1'b0;
    show   = !a_blank[kk] && (!sup || a_dp[kk]) && (tt >= BT) && (tt < BT + on_ticks);
    e.en   = show ? ~(4'b0001 << kk) : 4'hF;
    e.data = {a_dp[kk], sup ? 7'h00 : glyph_tab[a_digits[4*kk +: 4]]};
    e.cur  = 4'(kk);
    e.fd   = (c > 0) && (c % NDT == 0);
    return e;
  endfunction

  task automatic check(input string name, input exp_t e);
    n_chk++;
    if (seg_en !== e.en || seg_data !== e.data || cur_digit !== e.cur || frame_done !== e.fd) begin
      n_fail++;
      $display("FAIL %s @%0t: got en=%h data=%h cur=%0d fd=%b, expected en=%h data=%h cur=%0d fd=%b",
               name, $time, seg_en, seg_data, cur_digit, frame_done, e.en, e.data, e.cur, e.fd);
    end
  endtask

  // One scan cycle: predict its output, advance the buffer model, then move past the edge.
  task automatic step();
    exp_q.push_back(expect_cycle(cyc));
    if (cyc % NDT == NDT - 1) begin
      a_digits = p_digits; a_dp = p_dp; a_blank = p_blank; a_lz = p_lz; a_bright = p_bright;
    end
    if (load) begin
      p_digits = digits_bcd; p_dp = dp_mask; p_blank = blank_mask;
      p_lz = lz_suppress; p_bright = bright;
    end
    cyc++;
    @(posedge clk);
    #1;
    load        = 1'b0;
    digits_bcd  = 16'($urandom);
    dp_mask     = 4'($urandom);
    blank_mask  = 4'($urandom);
    lz_suppress = 1'($urandom);
    bright      = 2'($urandom);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                         input logic lz, input logic [1:0] br);
    digits_bcd = d; dp_mask = dp; blank_mask = bl; lz_suppress = lz; bright = br;
    load = 1'b1;
    step();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic step_until(input int pos);
    while (cyc % NDT != pos) step();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    resetn = 1'b1;
    cyc    = 0;
    clear_model();
  endtask

  // Monitor: outputs during reset must be inactive; otherwise each clocked cycle pops one entry.
  initial begin : monitor
    bit live;
    forever begin
      @(posedge clk);
      live = resetn;
      @(negedge clk);
      if (!resetn) begin
        check("reset", '{en: 4'hF, data: 8'h00, cur: 4'h0, fd: 1'b0});
      end else if (live) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL underflow @%0t: DUT output cycle with no prediction queued", $time);
        end else begin
          check("scan", exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [15:0] d;
    resetn = 1'b0; load = 1'b0; digits_bcd = '0; dp_mask = '0; blank_mask = '0;
    lz_suppress = 1'b0; bright = '0;
    clear_model();
    repeat (4) @(posedge clk);
    release_reset();

    // Idle after reset: zeros at the minimum brightness, frame_done every NDT cycles.
    run(2 * NDT);

    // Decode and full-brightness timing.
    do_load(16'h1234, 4'h0, 4'h0, 1'b0, 2'd3);
    step_until(0);
    run(NDT);

    // PWM widths at the two lowest levels.
    do_load(16'h1234, 4'h0, 4'h0, 1'b0, 2'd0);
    step_until(0);
    run(NDT);
    do_load(16'h1234, 4'h0, 4'h0, 1'b0, 2'd1);
    step_until(0);
    run(NDT);

    // Leading-zero suppression with a dp on a suppressed digit, then an all-zero value.
    do_load(16'h0070, 4'b1000, 4'h0, 1'b1, 2'd3);
    step_until(0);
    run(NDT);
    do_load(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3);
    step_until(0);
    run(NDT);

    // Double buffering: overwrite mid-frame, then a load on the wrap cycle is deferred.
    step_until(10);
    do_load(16'h1111, 4'h0, 4'h0, 1'b0, 2'd3);
    step_until(30);
    do_load(16'h2222, 4'h0, 4'h0, 1'b0, 2'd3);
    step_until(0);
    run(NDT);
    step_until(NDT - 1);
    do_load(16'h5678, 4'b0101, 4'b0010, 1'b0, 2'd2);
    run(2 * NDT);

    // Randomised loads at random points, including masks and zero-heavy digit patterns.
    repeat (12 * NDT) begin
      if ($urandom_range(39, 0) == 0) begin
        for (int j = 0; j < N; j++)
          d[4*j +: 4] = ($urandom_range(1, 0) == 1) ? 4'h0 : 4'($urandom_range(15, 0));
        do_load(d, 4'($urandom), 4'($urandom_range(3, 0) == 0 ? $urandom : 0),
                1'($urandom), 2'($urandom));
      end else begin
        step();
      end
    end

    // Asynchronous reset in the middle of digit 2's lit window.
    do_load(16'h9876, 4'hF, 4'h0, 1'b0, 2'd3);
    step_until(0);
    step_until(2 * DT + 10);
    resetn = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    release_reset();
    run(NDT + 5);

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
